pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Sequences the six-stage pipeline (IF, ID, RF, EX, DM, WB) where no operand forwarding exists. It tracks every in-flight register writer from EX through WB and holds IF/ID/RF while the instruction in RF reads a pending register. It also squashes wrong-path instructions when DM reports a branch misprediction. It drives the stall enables and flush controls for the pipeline registers, and the datapath's writeback qualifiers.

## Interface

Parameters:
- XLEN, 32, datapath width; sets the width of the optional performance counters.
- WB_WRITE_THROUGH, 0, set to 1 when the register file returns same-cycle WB write data on read; the WB slot is then excluded from hazard checks.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  reset; one clock; reset is asynchronous and active-high.
- rf_rs1_index  input  5  RF-stage source 1 index.
- rf_rs2_index  input  5  RF-stage source 2 index.
- rf_rs1_used  input  1  RF instruction reads rs1.
- rf_rs2_used  input  1  RF instruction reads rs2.
- rf_rd_index  input  5  RF-stage destination index.
- rf_write_en  input  1  RF instruction writes rd.
- dm_branch_mispredicted  input  1  DM-stage branch evaluator misprediction.
- stall  output  1  hold PC, IF/ID and ID/RF registers.
- bubble_ex  output  1  load a NOP (all-zero control) into RF/EX.
- flush_front  output  1  zero IF/ID, ID/RF and RF/EX control.
- flush_ex_dm  output  1  zero EX/DM control.
- rf_valid  output  1  RF stage holds a live instruction.
- wb_valid  output  1  WB stage holds a live instruction; gates register file write.

## Operation

- Internal valid bits id_v, rf_v, ex_v, dm_v, wb_v, plus a tracker slot {valid, rd} for each of EX, DM and WB.
- A slot is created only when rf_v=1, rf_write_en=1 and rf_rd_index≠0. The x0 register is never tracked.
- hazard = rf_v and (src1_hit or src2_hit).
  - srcN_hit = rf_rsN_used, rf_rsN_index≠0, and equal to the rd of any valid EX, DM or WB slot. The WB slot is excluded when WB_WRITE_THROUGH=1.
- stall = hazard and not dm_branch_mispredicted.
- bubble_ex = stall.
- flush_front = flush_ex_dm = dm_branch_mispredicted.
- Priority: misprediction > hazard > normal advance.
- Clock edge, normal advance:
  - id_v←1, rf_v←id_v, ex←RF.
  - dm←ex, wb←dm.
- Clock edge, stall:
  - id_v and rf_v hold.
  - ex←invalid.
  - dm←ex, wb←dm.
- Clock edge, misprediction:
  - id_v←0, rf_v←0, ex←invalid, dm←invalid.
  - wb←dm (the branch itself retires).
  - Next cycle id_v←1 as the corrected fetch enters ID.
- Worst-case stall is 3 cycles, or 2 when WB_WRITE_THROUGH=1. Consecutive hazards re-evaluate every cycle.

## Timing

- stall, bubble_ex, flush_front and flush_ex_dm are combinational from the current state and inputs in the same cycle. There are no registered outputs except rf_valid and wb_valid (direct state).
- The tracker updates on the rising edge of clk.
- Reset (asynchronous assert, released synchronous to clk):
  - All valid bits and slots are cleared, so rf_valid=0 and wb_valid=0.
  - stall, bubble_ex, flush_front and flush_ex_dm are forced to 0 while reset=1, regardless of inputs.
- After reset deassertion:
  - First edge: id_v=1.
  - Second edge: rf_v=1.
  - Hazards cannot fire before rf_v=1.
- Reset asserted mid-stall or mid-flush: all state is cleared immediately. There is no residual stall after release.
- Misprediction coincident with a hazard: only the flush is performed and stall=0. The hazard is discarded with the squashed RF instruction.

## Configuration

- HAZARD_PERF_COUNTERS_EN:
  - Defined: adds outputs stall_cycles and flush_count, each XLEN bits and reset to 0.
    - stall_cycles increments on each edge where stall=1.
    - flush_count increments on each edge where dm_branch_mispredicted=1.
    - Both wrap from 2^XLEN−1 to 0.
  - Undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Test plan

- Back-to-back RAW:
  - Stimulus: RF issues rd=5 write, then the next instruction reads rs1=5 (WB_WRITE_THROUGH=0).
  - Required response: stall=1 for exactly 3 cycles, bubble_ex=1 in each, then advance.
  - Repeat with WB_WRITE_THROUGH=1: stall for exactly 2 cycles.
- x0 immunity:
  - Stimulus: writer rd=0, then reader rs1=0 and rs2=0.
  - Required response: stall never asserts.
- Unused source:
  - Stimulus: writer rd=7, then reader rs2_index=7 with rf_rs2_used=0.
  - Required response: no stall.
- Misprediction:
  - Stimulus: dm_branch_mispredicted=1 for one cycle while EX holds a writer of rd=9 and RF reads rs1=9.
  - Required response: flush_front=1, flush_ex_dm=1 and stall=0 that cycle.
  - Next cycle: rf_valid=0 and no slot holds rd=9.
  - Cycle after: rf_valid=0. It returns to 1 one cycle later.
- Reset mid-stall:
  - Stimulus: assert reset during the 2nd stall cycle.
  - Required response: stall=0 and rf_valid=0 immediately, without waiting for a clock edge. After release, rf_valid=1 on the 2nd edge.
- Counters (HAZARD_PERF_COUNTERS_EN defined):
  - Stimulus: one 3-cycle stall and 2 mispredictions.
  - Required response: stall_cycles=3 and flush_count=2.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Interlock and flush sequencer for a six-stage pipeline with no forwarding
// (IF, ID, RF, EX, DM, WB). It tracks the destination register of every live
// writer in EX, DM and WB. IF/ID/RF are held while the RF instruction reads a
// pending register. Wrong-path work is squashed on a DM misprediction.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN adds stall_cycles and
// flush_count outputs (XLEN bits each).
module pipeline_hazard_controller #(
   parameter int XLEN             = 32,
   parameter bit WB_WRITE_THROUGH = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rf_rs1_index,
   input  logic [4:0]      rf_rs2_index,
   input  logic            rf_rs1_used,
   input  logic            rf_rs2_used,
   input  logic [4:0]      rf_rd_index,
   input  logic            rf_write_en,
   input  logic            dm_branch_mispredicted,
   output logic            stall,
   output logic            bubble_ex,
   output logic            flush_front,
   output logic            flush_ex_dm,
   output logic            rf_valid,
   output logic            wb_valid
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [XLEN-1:0] stall_cycles,
   output logic [XLEN-1:0] flush_count
`endif
);

   // Live-instruction bits per stage.
   logic       id_v, rf_v, ex_v, dm_v, wb_v;
   // Writer tracker slots: valid only for live writers with rd != x0.
   logic       ex_sv, dm_sv, wb_sv;
   logic [4:0] ex_rd, dm_rd, wb_rd;

   logic       src1_hit, src2_hit, hazard, new_slot;

   // A source hits when it names a pending non-x0 destination.
   function automatic logic pending(input logic [4:0] idx,
                                    input logic ev, input logic [4:0] er,
                                    input logic dv, input logic [4:0] dr,
                                    input logic wv, input logic [4:0] wr);
      logic wb_chk;
      wb_chk = wv && (wr == idx) && !WB_WRITE_THROUGH;
      return (idx != 5'd0) && ((ev && (er == idx)) || (dv && (dr == idx)) || wb_chk);
   endfunction

   // Hazard detection and control outputs (combinational, gated by reset).
   always_comb begin
      src1_hit    = rf_rs1_used && pending(rf_rs1_index, ex_sv, ex_rd, dm_sv, dm_rd, wb_sv, wb_rd);
      src2_hit    = rf_rs2_used && pending(rf_rs2_index, ex_sv, ex_rd, dm_sv, dm_rd, wb_sv, wb_rd);
      hazard      = rf_v && (src1_hit || src2_hit);
      new_slot    = rf_v && rf_write_en && (rf_rd_index != 5'd0);
      stall       = !reset && hazard && !dm_branch_mispredicted;
      bubble_ex   = stall;
      flush_front = !reset && dm_branch_mispredicted;
      flush_ex_dm = flush_front;
   end

   assign rf_valid = rf_v;
   assign wb_valid = wb_v;

   // Stage valid bits and tracker: misprediction > stall > advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_v  <= 1'b0;
         rf_v  <= 1'b0;
         ex_v  <= 1'b0;
         dm_v  <= 1'b0;
         wb_v  <= 1'b0;
         ex_sv <= 1'b0;
         dm_sv <= 1'b0;
         wb_sv <= 1'b0;
         ex_rd <= 5'd0;
         dm_rd <= 5'd0;
         wb_rd <= 5'd0;
      end else begin
         // WB always takes DM: the mispredicting branch itself retires.
         wb_v  <= dm_v;
         wb_sv <= dm_sv;
         wb_rd <= dm_rd;
         if (dm_branch_mispredicted) begin
            id_v  <= 1'b0;
            rf_v  <= 1'b0;
            ex_v  <= 1'b0;
            ex_sv <= 1'b0;
            dm_v  <= 1'b0;
            dm_sv <= 1'b0;
         end else if (hazard) begin
            // Front end holds; a bubble enters EX.
            ex_v  <= 1'b0;
            ex_sv <= 1'b0;
            dm_v  <= ex_v;
            dm_sv <= ex_sv;
            dm_rd <= ex_rd;
         end else begin
            id_v  <= 1'b1;
            rf_v  <= id_v;
            ex_v  <= rf_v;
            ex_sv <= new_slot;
            ex_rd <= rf_rd_index;
            dm_v  <= ex_v;
            dm_sv <= ex_sv;
            dm_rd <= ex_rd;
         end
      end
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   // Event counters; both wrap naturally at 2^XLEN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall)                  stall_cycles <= stall_cycles + 1'b1;
         if (dm_branch_mispredicted) flush_count  <= flush_count + 1'b1;
      end
   end
`endif

endmodule
